scalar_wb_ctrl: RTL and testbench
=================================

SCALAR_WB_CTRL -- requirements
Module: scalar_wb_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: scalar data width.
REQ-002 The block SHALL have parameter NUM_ESC_REGS, default 32: scalar registers addressable.
REQ-003 The block SHALL have parameter ADDR_W, default 5: register address width, which equals ceil(log2(NUM_ESC_REGS)).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit used when REQ-027 applies.
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port req_valid, input, 1: a decode request for a scalar destination write.
REQ-008 Port req_addr, input, ADDR_W: the destination register of that request.
REQ-009 Port req_ready, output, 1: the request is accepted when both req_valid and req_ready are 1.
REQ-010 Port res_valid, input, 1: producer result strobe.
REQ-011 Port res_data, input, DATA_WIDTH: result value.
REQ-012 Port res_ready, output, 1: the result is accepted when both res_valid and res_ready are 1.
REQ-013 Port rf_we, output, 1: write reservation to the scalar register file.
REQ-014 Port rf_addr_w, output, ADDR_W: the register being reserved.
REQ-015 Port rf_write_data, output, DATA_WIDTH+2: bit [DATA_WIDTH+1] is valid, bit [DATA_WIDTH] is mask, and bits [DATA_WIDTH-1:0] are data.
REQ-016 Port rf_w_busy, input, 1: the register file's write-busy flag.
REQ-017 Ports rd_addr_a and rd_addr_b, input, ADDR_W each: read addresses to hazard-check.
REQ-018 Ports hazard_a and hazard_b, output, 1 each: the matching read address targets the pending register.
REQ-019 Port err_timeout, output, 1: sticky watchdog error flag.

Function
REQ-020 The FSM SHALL have three states: IDLE, RESV and WAIT.
- IDLE: req_ready = !rf_w_busy; on handshake, latch req_addr into pend_addr and go to RESV.
- RESV: assert rf_we = 1 and rf_addr_w = pend_addr for exactly one cycle, then go to WAIT.
- WAIT: when rf_w_busy = 1 and the FIFO is non-empty, drive rf_write_data = {1, 1, FIFO head} for one cycle, pop the FIFO and go to IDLE.
REQ-021 rf_write_data SHALL be all-zero in every cycle except the WAIT data cycle, and rf_addr_w SHALL be 0 outside RESV.
REQ-022 The 2-entry in-order result FIFO SHALL meet the following:
- res_ready = !full.
- Results may arrive before their reservation and are held.
- A push and a pop in the same cycle are both honoured.
- Pointers wrap modulo 2.
REQ-023 Latency SHALL be as follows for a request accepted in cycle N with a result already buffered:
- rf_we is asserted in cycle N+1.
- Data is presented in cycle N+2.
- req_ready is high again in cycle N+3, provided rf_w_busy has cleared.
REQ-024 hazard_x SHALL equal (state != IDLE) && (rd_addr_x == pend_addr), computed combinationally.
REQ-025 A req_valid that arrives while rf_w_busy = 1 in IDLE SHALL stall, with no reservation issued.
REQ-026 req_ready SHALL be 0 in RESV and in WAIT, so that at most one reservation is outstanding.

Reset
REQ-027 While rst is asserted, the block SHALL force the following asynchronously:
- State = IDLE.
- FIFO empty, pointers = 0.
- pend_addr = 0.
- Watchdog counter = 0.
- err_timeout = 0.
REQ-028 Output values SHALL follow from that reset state:
- rf_we = 0, rf_write_data = 0, hazard_a = 0, hazard_b = 0.
- res_ready = 1, and req_ready = !rf_w_busy.
REQ-029 A reset asserted mid-operation SHALL discard the pending reservation and any buffered results, with no write issued.

Configuration
REQ-030 With SCALAR_WB_TIMEOUT_EN defined, the block SHALL include the watchdog:
- An 8-bit or wider counter clears on entry to WAIT and increments on each WAIT cycle without a data write.
- When the count reaches TIMEOUT_CYCLES, the block drives rf_write_data = {1, 0, 0} for one cycle to release the busy flag, sets err_timeout (held until reset) and returns to IDLE.
REQ-031 Without SCALAR_WB_TIMEOUT_EN, the block SHALL omit the counter, SHALL wait in WAIT indefinitely, and SHALL tie err_timeout to 0.

Verification
REQ-032 Basic write: with rf_w_busy following the register file, push res_data = 0x40A00000, then request req_addr = 5. Required: rf_we pulses with addr 5 one cycle after acceptance, followed by a single rf_write_data pulse {1, 1, 0x40A00000}, and register 5 reads 0x40A00000.
REQ-033 Result late: request addr 9, then hold res_valid low for 10 cycles before sending 0x8. Required: the block stays in WAIT, hazard_a = 1 for rd_addr_a = 9 throughout, the write occurs in the cycle after res_valid, and hazard_a then drops.
REQ-034 FIFO full: push 3 results with no requests. Required: res_ready goes low after the 2nd push. Two requests (addr 3, then 4) then receive the 1st and 2nd values in order.
REQ-035 Busy stall: hold rf_w_busy = 1 while idle with req_valid = 1. Required: req_ready = 0 and rf_we stays 0 until rf_w_busy falls.
REQ-036 Reset in WAIT: assert rst for 1 cycle mid-wait. Required: all outputs go to their reset values immediately, and no rf_write_data valid pulse is ever issued for the lost request.
REQ-037 Timeout (macro defined, TIMEOUT_CYCLES = 4): request with no result. Required: rf_write_data = {1, 0, 0} after 4 WAIT cycles, err_timeout goes to 1 and stays there, and the block returns to IDLE.

Source files
------------

// File: rtl/scalar_wb_ctrl.sv
// scalar_wb_ctrl: scalar write-back controller (reserve dest reg, then forward in-order result)
// Ports: clk/rst (async active-high); req_valid/req_addr/req_ready decode request;
// res_valid/res_data/res_ready producer results into a 2-entry FIFO;
// rf_we/rf_addr_w reservation, rf_write_data {valid,mask,data}, rf_w_busy from the reg file;
// rd_addr_a/b -> hazard_a/b against the pending register; err_timeout sticky watchdog flag.
// Optional watchdog: define SCALAR_WB_TIMEOUT_EN.
module scalar_wb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ESC_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  req_ready,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ready,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_addr_w,
  output logic [DATA_WIDTH+1:0] rf_write_data,
  input  logic                  rf_w_busy,
  input  logic [ADDR_W-1:0]     rd_addr_a,
  input  logic [ADDR_W-1:0]     rd_addr_b,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic                  err_timeout
);
  typedef enum logic [1:0] {IDLE, RESV, WAIT} state_t;
  if (ADDR_W < $clog2(NUM_ESC_REGS) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("scalar_wb_ctrl: ADDR_W too narrow or TIMEOUT_CYCLES < 1");
  end
  state_t state, state_n;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] count;
  logic push, pop, tout;
  assign res_ready = count != 2'd2;
  assign push = res_valid && res_ready;
  // data goes out only once the reg file shows the reservation as busy
  assign pop = state == WAIT && rf_w_busy && count != 2'd0;
  assign hazard_a = state != IDLE && rd_addr_a == pend_addr;
  assign hazard_b = state != IDLE && rd_addr_b == pend_addr;
`ifdef SCALAR_WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wd_cnt;
  logic err_q;
  assign tout = state == WAIT && !pop && wd_cnt == CW'(TIMEOUT_CYCLES);
  assign err_timeout = err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      wd_cnt <= state == RESV ? '0 : (state == WAIT && !pop && !tout) ? wd_cnt + 1'b1 : wd_cnt;
      err_q <= err_q || tout;
    end
`else
  assign tout = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pend_addr <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      state <= state_n;
      if (req_valid && req_ready) pend_addr <= req_addr;
      if (push) wr_ptr <= !wr_ptr;
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= res_data;
  always_comb begin
    state_n = state;
    req_ready = 1'b0;
    rf_we = 1'b0;
    rf_addr_w = '0;
    rf_write_data = '0;
    case (state)
      IDLE: begin
        req_ready = !rf_w_busy;
        state_n = req_valid && !rf_w_busy ? RESV : IDLE;
      end
      RESV: begin
        rf_we = 1'b1;
        rf_addr_w = pend_addr;
        state_n = WAIT;
      end
      WAIT: begin
        // a timeout writes valid without mask: releases busy, leaves the register untouched
        rf_write_data = pop ? {2'b11, fifo[rd_ptr]} : tout ? {2'b10, {DATA_WIDTH{1'b0}}} : '0;
        state_n = pop || tout ? IDLE : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_scalar_wb_ctrl.sv
// tb_scalar_wb_ctrl: self-checking bench for scalar_wb_ctrl with a register-file model
module tb_scalar_wb_ctrl;
  localparam int DW = 32, AW = 5, TO = 4;
`ifdef SCALAR_WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int LATE = TO_EN ? 2 : 10;
  typedef struct {
    logic rv;
    logic [AW-1:0] ra;
    logic sv;
    logic [DW-1:0] sd;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [44:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, res_valid = 1'b0, force_busy = 1'b0, rf_busy;
  logic [AW-1:0] req_addr = '0, rd_addr_a = '0, rd_addr_b = '0, rf_addr_w, rf_raddr;
  logic [DW-1:0] res_data = '0;
  logic req_ready, res_ready, rf_we, hazard_a, hazard_b, err_timeout, rf_w_busy;
  logic [DW+1:0] rf_write_data;
  logic [DW-1:0] regs [32];
  logic [44:0] obs;
  int total = 0, bad = 0;
  vec_t tv [19];
  scalar_wb_ctrl #(.DATA_WIDTH(DW), .NUM_ESC_REGS(32), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .rf_we(rf_we),
    .rf_addr_w(rf_addr_w), .rf_write_data(rf_write_data), .rf_w_busy(rf_w_busy),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .err_timeout(err_timeout));
  always #5 clk = ~clk;
  assign rf_w_busy = rf_busy | force_busy;
  assign obs = {req_ready, res_ready, rf_we, hazard_a, hazard_b, err_timeout, rf_addr_w, rf_write_data};
  // register file: busy from reservation until a valid write; mask gates the data update
  always @(posedge clk or posedge rst)
    if (rst) rf_busy <= 1'b0;
    else if (rf_we) begin
      rf_busy <= 1'b1;
      rf_raddr <= rf_addr_w;
    end else if (rf_write_data[DW+1]) begin
      rf_busy <= 1'b0;
      if (rf_write_data[DW]) regs[rf_raddr] <= rf_write_data[DW-1:0];
    end
  function automatic logic [44:0] mk(bit rr, bit sr, bit we, bit ha, bit hb, bit er,
                                     logic [AW-1:0] ad, logic [DW+1:0] wd);
    return {rr, sr, we, ha, hb, er, ad, wd};
  endfunction
  task automatic chk(string n, logic [44:0] got, logic [44:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", n, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic rv, logic [AW-1:0] ra, logic sv, logic [DW-1:0] sd,
                       logic [AW-1:0] a, logic [AW-1:0] b);
    req_valid = rv;
    req_addr = ra;
    res_valid = sv;
    res_data = sd;
    rd_addr_a = a;
    rd_addr_b = b;
  endtask
  task automatic rst_pulse;
    drive(0, 0, 0, 0, 0, 0);
    force_busy = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask
  localparam logic [DW+1:0] Z = '0;
  initial begin
    int pulses;
    int q[$];
    bit pend, fresh, err, busy, data, tmo, acc;
    logic [AW-1:0] paddr;
    int waited, sz;
    logic [DW+1:0] wd;
    tv[0]  = '{0, 0, 1, 32'h40A00000, 5, 6, mk(1, 1, 0, 0, 0, 0, 0, Z)};
    tv[1]  = '{1, 5, 0, 0, 5, 6, mk(1, 1, 0, 0, 0, 0, 0, Z)};
    tv[2]  = '{0, 0, 0, 0, 5, 6, mk(0, 1, 1, 1, 0, 0, 5, Z)};
    tv[3]  = '{0, 0, 0, 0, 5, 5, mk(0, 1, 0, 1, 1, 0, 0, {2'b11, 32'h40A00000})};
    tv[4]  = '{0, 0, 0, 0, 5, 5, mk(1, 1, 0, 0, 0, 0, 0, Z)};
    tv[5]  = '{0, 0, 1, 32'h11, 3, 4, mk(1, 1, 0, 0, 0, 0, 0, Z)};
    tv[6]  = '{0, 0, 1, 32'h22, 3, 4, mk(1, 1, 0, 0, 0, 0, 0, Z)};
    tv[7]  = '{0, 0, 1, 32'h33, 3, 4, mk(1, 0, 0, 0, 0, 0, 0, Z)};
    tv[8]  = '{1, 3, 0, 0, 3, 4, mk(1, 0, 0, 0, 0, 0, 0, Z)};
    tv[9]  = '{0, 0, 0, 0, 3, 4, mk(0, 0, 1, 1, 0, 0, 3, Z)};
    tv[10] = '{0, 0, 1, 32'h44, 3, 4, mk(0, 0, 0, 1, 0, 0, 0, {2'b11, 32'h11})};
    tv[11] = '{1, 4, 0, 0, 3, 4, mk(1, 1, 0, 0, 0, 0, 0, Z)};
    tv[12] = '{0, 0, 0, 0, 3, 4, mk(0, 1, 1, 0, 1, 0, 4, Z)};
    tv[13] = '{0, 0, 1, 32'h55, 3, 4, mk(0, 1, 0, 0, 1, 0, 0, {2'b11, 32'h22})};
    tv[14] = '{0, 0, 0, 0, 3, 4, mk(1, 1, 0, 0, 0, 0, 0, Z)};
    tv[15] = '{1, 6, 0, 0, 6, 0, mk(1, 1, 0, 0, 0, 0, 0, Z)};
    tv[16] = '{0, 0, 0, 0, 6, 0, mk(0, 1, 1, 1, 0, 0, 6, Z)};
    tv[17] = '{0, 0, 0, 0, 6, 0, mk(0, 1, 0, 1, 0, 0, 0, {2'b11, 32'h55})};
    tv[18] = '{0, 0, 0, 0, 6, 0, mk(1, 1, 0, 0, 0, 0, 0, Z)};
    #1 rst = 1'b1;
    #1 chk("reset_state", obs, mk(1, 1, 0, 0, 0, 0, 0, Z));
    tick;
    tick;
    rst = 1'b0;
    foreach (tv[i]) begin
      drive(tv[i].rv, tv[i].ra, tv[i].sv, tv[i].sd, tv[i].a, tv[i].b);
      #1 chk($sformatf("vec%0d", i), obs, tv[i].exp);
      tick;
    end
    chk("reg5", 45'(regs[5]), 45'(32'h40A00000));
    chk("reg3", 45'(regs[3]), 45'(32'h11));
    chk("reg4", 45'(regs[4]), 45'(32'h22));
    chk("reg6", 45'(regs[6]), 45'(32'h55));
    // busy stall
    rst_pulse;
    force_busy = 1'b1;
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall", obs, mk(0, 1, 0, 0, 0, 0, 0, Z));
      tick;
    end
    force_busy = 1'b0;
    #1 chk("stall_release", obs, mk(1, 1, 0, 0, 0, 0, 0, Z));
    tick;
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("stall_resv", obs, mk(0, 1, 1, 0, 0, 0, 1, Z));
    // late result
    rst_pulse;
    drive(1, 9, 0, 0, 9, 0);
    #1 chk("late_accept", obs, mk(1, 1, 0, 0, 0, 0, 0, Z));
    tick;
    drive(0, 0, 0, 0, 9, 0);
    #1 chk("late_resv", obs, mk(0, 1, 1, 1, 0, 0, 9, Z));
    tick;
    for (int i = 0; i < LATE; i++) begin
      #1 chk("late_wait", obs, mk(0, 1, 0, 1, 0, 0, 0, Z));
      tick;
    end
    drive(0, 0, 1, 32'h8, 9, 0);
    #1 chk("late_push", obs, mk(0, 1, 0, 1, 0, 0, 0, Z));
    tick;
    drive(0, 0, 0, 0, 9, 0);
    #1 chk("late_write", obs, mk(0, 1, 0, 1, 0, 0, 0, {2'b11, 32'h8}));
    tick;
    #1 chk("late_done", obs, mk(1, 1, 0, 0, 0, 0, 0, Z));
    // reset while waiting
    rst_pulse;
    drive(1, 7, 0, 0, 7, 0);
    tick;
    drive(0, 0, 0, 0, 7, 0);
    tick;
    #1 chk("rst_wait_pre", obs, mk(0, 1, 0, 1, 0, 0, 0, Z));
    rst = 1'b1;
    #1 chk("rst_async", obs, mk(1, 1, 0, 0, 0, 0, 0, Z));
    tick;
    rst = 1'b0;
    drive(0, 0, 1, 32'hABCD, 7, 0);
    tick;
    drive(0, 0, 0, 0, 7, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      #1 if (rf_write_data[DW+1]) pulses++;
      tick;
    end
    chk("rst_no_write", 45'(pulses), 45'(0));
    // watchdog
    rst_pulse;
    drive(1, 2, 0, 0, 2, 0);
    tick;
    drive(0, 0, 0, 0, 2, 0);
    tick;
    for (int i = 0; i < TO; i++) begin
      #1 chk("wd_wait", obs, mk(0, 1, 0, 1, 0, 0, 0, Z));
      tick;
    end
`ifdef SCALAR_WB_TIMEOUT_EN
    #1 chk("wd_release", obs, mk(0, 1, 0, 1, 0, 0, 0, {2'b10, 32'h0}));
    tick;
    #1 chk("wd_err", obs, mk(1, 1, 0, 0, 0, 1, 0, Z));
    repeat (5) tick;
    #1 chk("wd_sticky", obs, mk(1, 1, 0, 0, 0, 1, 0, Z));
`else
    repeat (300) tick;
    #1 chk("wd_forever", obs, mk(0, 1, 0, 1, 0, 0, 0, Z));
`endif
    // randomized run against a transaction-level model
    rst_pulse;
    pend = 0;
    fresh = 0;
    err = 0;
    paddr = '0;
    waited = 0;
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
            $urandom, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      force_busy = $urandom_range(0, 9) == 0;
      #1 busy = rf_w_busy;
      sz = q.size();
      data = pend && !fresh && busy && sz > 0;
      tmo = TO_EN && pend && !fresh && !data && waited == TO;
      wd = data ? {2'b11, DW'(q[0])} : tmo ? {2'b10, 32'h0} : Z;
      chk("rand", obs, mk(!pend && !busy, sz < 2, fresh, pend && rd_addr_a == paddr,
                          pend && rd_addr_b == paddr, err, fresh ? paddr : '0, wd));
      acc = req_valid && !pend && !busy;
      if (pend && !fresh && !data && !tmo) waited++;
      if (data) begin
        void'(q.pop_front());
        pend = 0;
      end
      if (tmo) begin
        pend = 0;
        err = 1;
      end
      if (res_valid && sz < 2) q.push_back(int'(res_data));
      fresh = 0;
      if (acc) begin
        pend = 1;
        fresh = 1;
        paddr = req_addr;
        waited = 0;
      end
      tick;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
